// File: rtl/csi_crc_checker_pkg.sv
// rtl/csi_crc_checker_pkg.sv - shared types, constants and byte-wise CRC16 helper
package csi_crc_pkg;

    localparam logic [15:0] CRC_SEED = 16'hFFFF;
    // x^16+x^12+x^5+1 bit-reversed for LSB-first shifting
    localparam logic [15:0] CRC_POLY_REV = 16'h8408;

    typedef enum logic [1:0] {IDLE, PAYLOAD, CSUM} state_e;
    typedef enum logic [1:0] {PAY, CLO, CHI, PAD} lane_class_e;

    function automatic logic [15:0] crc16_byte(logic [15:0] crc, logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {8'h00, b};
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REV) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/csi_crc_checker_if.sv
// rtl/csi_crc_checker_if.sv - packet stream input and checksum result bundle
interface csi_crc_checker_if #(
    parameter int LANES = 4
);
    logic                 pktStart;
    logic [15:0]          wordCount;
    logic                 dataValid;
    logic [8*LANES-1:0]   data;
    logic                 busy;
    logic                 crcValid;
    logic                 crcOk;
    logic [15:0]          crcCalc;
    logic [15:0]          crcRecv;
    logic                 abort;

    modport master (
        output pktStart, wordCount, dataValid, data,
        input  busy, crcValid, crcOk, crcCalc, crcRecv, abort
    );

    modport slave (
        input  pktStart, wordCount, dataValid, data,
        output busy, crcValid, crcOk, crcCalc, crcRecv, abort
    );
endinterface

// File: rtl/csi_crc_checker_crc16.sv
// rtl/csi_crc_checker_crc16.sv - one byte CRC16 stage with lane-enable bypass
module crc16_parallel
    import csi_crc_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [7:0]  byte_i,
    input  logic        en_i,
    output logic [15:0] crc_o
);
    assign crc_o = en_i ? crc16_byte(crc_i, byte_i) : crc_i;
endmodule

// File: rtl/csi_crc_checker.sv
// rtl/csi_crc_checker.sv - CSI-2 long-packet payload CRC sequencer and checker
module csi_crc_checker
    import csi_crc_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             reset,
    csi_crc_checker_if.slave bus
);
    state_e      state_q, state_d;
    logic [16:0] count_q, count_d, total_q, total_d, count_sum, count_adv;
    logic [15:0] wc_q, wc_d, crc_q, crc_d, calc_q, calc_d, recv_q, recv_d;
    logic [7:0]  lo_q, lo_d, lo_byte, hi_byte;
    logic        ok_q, ok_d, valid_q, valid_d, abort_q, abort_d;
    logic        beat, done;
    logic [LANES-1:0] lane_en;
    logic [15:0] chain [LANES+1];

    assign beat      = bus.dataValid && !bus.pktStart && (state_q != IDLE);
    assign count_sum = count_q + 17'(LANES);
    assign count_adv = (count_sum > total_q) ? total_q : count_sum;

    // Lane i holds stream byte count+i; a low checksum byte seen on an
    // earlier beat is carried in lo_q until the high byte arrives.
    always_comb begin
        logic [17:0] idx;
        lane_class_e cls;
        idx     = '0;
        cls     = PAD;
        lane_en = '0;
        lo_byte = lo_q;
        hi_byte = 8'h00;
        done    = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            idx = {1'b0, count_q} + 18'(i);
            if (idx < {2'b00, wc_q})                 cls = PAY;
            else if (idx == {2'b00, wc_q})           cls = CLO;
            else if (idx == {2'b00, wc_q} + 18'd1)   cls = CHI;
            else                                     cls = PAD;
            if (beat) begin
                case (cls)
                    PAY: lane_en[i] = 1'b1;
                    CLO: lo_byte = bus.data[8*i +: 8];
                    CHI: begin
                        hi_byte = bus.data[8*i +: 8];
                        done    = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign chain[0] = crc_q;
    for (genvar g = 0; g < LANES; g++) begin : g_stage
        crc16_parallel u_stage (
            .crc_i  (chain[g]),
            .byte_i (bus.data[8*g +: 8]),
            .en_i   (lane_en[g]),
            .crc_o  (chain[g+1])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.pktStart) begin
            state_d = PAYLOAD;
        end else begin
            case (state_q)
                PAYLOAD: begin
                    if (done)                                    state_d = IDLE;
                    else if (beat && count_adv >= {1'b0, wc_q})  state_d = CSUM;
                end
                CSUM:    if (done) state_d = IDLE;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy = (state_q != IDLE);
    end

    always_comb begin
        count_d = count_q;
        total_d = total_q;
        wc_d    = wc_q;
        crc_d   = crc_q;
        lo_d    = lo_q;
        calc_d  = calc_q;
        recv_d  = recv_q;
        ok_d    = ok_q;
        valid_d = 1'b0;
        abort_d = bus.pktStart && (state_q != IDLE);
        if (bus.pktStart) begin
            wc_d    = bus.wordCount;
            total_d = {1'b0, bus.wordCount} + 17'd2;
            count_d = '0;
            crc_d   = CRC_SEED;
        end else if (beat) begin
            count_d = count_adv;
            crc_d   = chain[LANES];
            lo_d    = lo_byte;
            if (done) begin
                calc_d  = chain[LANES];
                recv_d  = {hi_byte, lo_byte};
                ok_d    = (chain[LANES] == {hi_byte, lo_byte});
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            total_q <= '0;
            wc_q    <= '0;
            crc_q   <= CRC_SEED;
            lo_q    <= '0;
            calc_q  <= '0;
            recv_q  <= '0;
            ok_q    <= 1'b0;
            valid_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            count_q <= count_d;
            total_q <= total_d;
            wc_q    <= wc_d;
            crc_q   <= crc_d;
            lo_q    <= lo_d;
            calc_q  <= calc_d;
            recv_q  <= recv_d;
            ok_q    <= ok_d;
            valid_q <= valid_d;
            abort_q <= abort_d;
        end
    end

    assign bus.crcValid = valid_q;
    assign bus.crcOk    = ok_q;
    assign bus.crcCalc  = calc_q;
    assign bus.crcRecv  = recv_q;
    assign bus.abort    = abort_q;
endmodule

// File: tb/tb_csi_crc_checker.sv
// tb/tb_csi_crc_checker.sv - self-checking bench for csi_crc_checker at LANES=1 and LANES=4
module tb_csi_crc_checker;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    csi_crc_checker_if #(.LANES(1)) if1();
    csi_crc_checker_if #(.LANES(4)) if4();

    csi_crc_checker #(.LANES(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
    csi_crc_checker #(.LANES(4)) dut4 (.clk(clk), .reset(reset), .bus(if4.slave));

    typedef struct {
        logic        valid;
        logic        ok;
        logic        busy;
        logic        abort;
        logic [15:0] calc;
        logic [15:0] recv;
    } res_t;

    typedef struct {
        int          lanes;
        int          vec;
        int          flip;
        bit          has_calc;
        logic [15:0] exp_calc;
        logic [15:0] exp_recv;
        bit          exp_ok;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int nval4 = 0;
    int nab4 = 0;
    logic [7:0] pkt_q[$];
    logic [191:0] v1_bits = 192'hFF000002B9DCF372BBD4B85AC875C27C81F805DFFF000001;
    logic [191:0] v2_bits = 192'hFF0000001EF01EC74F8278C582E08C70D23C78E9FF000001;

    always @(posedge clk) begin
        if (if4.crcValid) nval4 <= nval4 + 1;
        if (if4.abort)    nab4  <= nab4 + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference CRC: shift the payload in bit by bit, LSB first
    function automatic logic [15:0] model_crc(int n);
        logic [15:0] r;
        logic        fb;
        r = 16'hFFFF;
        for (int j = 0; j < n; j++) begin
            for (int k = 0; k < 8; k++) begin
                fb = r[0] ^ pkt_q[j][k];
                r  = {1'b0, r[15:1]};
                if (fb) r = r ^ 16'h8408;
            end
        end
        return r;
    endfunction

    task automatic drive(int lanes, logic ps, logic [15:0] wc, logic dv, logic [31:0] d);
        if (lanes == 1) begin
            if1.pktStart = ps; if1.wordCount = wc; if1.dataValid = dv; if1.data = d[7:0];
        end else begin
            if4.pktStart = ps; if4.wordCount = wc; if4.dataValid = dv; if4.data = d;
        end
    endtask

    function automatic res_t sample(int lanes);
        res_t r;
        if (lanes == 1) begin
            r.valid = if1.crcValid; r.ok = if1.crcOk; r.busy = if1.busy;
            r.abort = if1.abort; r.calc = if1.crcCalc; r.recv = if1.crcRecv;
        end else begin
            r.valid = if4.crcValid; r.ok = if4.crcOk; r.busy = if4.busy;
            r.abort = if4.abort; r.calc = if4.crcCalc; r.recv = if4.crcRecv;
        end
        return r;
    endfunction

    // Start a packet, then stream pkt_q bytes until at least `limit` are sent
    task automatic send_packet(int lanes, int wc, int limit, output logic ab, output res_t r);
        int idx;
        logic [31:0] d;
        drive(lanes, 1'b1, 16'(wc), 1'b1, $urandom);
        @(posedge clk); #1;
        r  = sample(lanes);
        ab = r.abort;
        check("busy_rise", {31'd0, r.busy}, 32'd1);
        idx = 0;
        while (idx < limit) begin
            if ($urandom_range(0, 3) == 0) begin
                drive(lanes, 1'b0, 16'h0, 1'b0, $urandom);
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            d = '0;
            for (int i = 0; i < lanes; i++) begin
                if (idx + i < pkt_q.size()) d[8*i +: 8] = pkt_q[idx + i];
                else                        d[8*i +: 8] = 8'($urandom);
            end
            drive(lanes, 1'b0, 16'h0, 1'b1, d);
            @(posedge clk); #1;
            idx += lanes;
        end
        drive(lanes, 1'b0, 16'h0, 1'b0, 32'h0);
        r = sample(lanes);
    endtask

    // pkt_q holds the payload; appends recv as the checksum and checks the result
    task automatic run_full(string tag, int lanes, logic [15:0] recv, bit idle_after, output res_t r);
        int          wc;
        logic [15:0] m;
        logic        ab;
        wc = pkt_q.size();
        m  = model_crc(wc);
        pkt_q.push_back(recv[7:0]);
        pkt_q.push_back(recv[15:8]);
        send_packet(lanes, wc, wc + 2, ab, r);
        check({tag, "_valid"}, {31'd0, r.valid}, 32'd1);
        check({tag, "_calc"},  {16'd0, r.calc},  {16'd0, m});
        check({tag, "_recv"},  {16'd0, r.recv},  {16'd0, recv});
        check({tag, "_ok"},    {31'd0, r.ok},    {31'd0, (m == recv)});
        check({tag, "_busy"},  {31'd0, r.busy},  32'd0);
        check({tag, "_noabort"}, {31'd0, ab},    32'd0);
        if (idle_after) begin
            @(posedge clk); #1;
            r.valid = sample(lanes).valid;
            check({tag, "_pulse1"}, {31'd0, r.valid}, 32'd0);
        end
    endtask

    task automatic load_vec(int vec, int flip);
        pkt_q.delete();
        if (vec != 2) begin
            for (int k = 0; k < 24; k++) begin
                if (vec == 0) pkt_q.push_back(v1_bits[191 - 8*k -: 8]);
                else          pkt_q.push_back(v2_bits[191 - 8*k -: 8]);
            end
        end
        if (flip >= 0) pkt_q[flip] = pkt_q[flip] ^ 8'hFF;
    endtask

    initial begin
        vec_t        tbl[7];
        res_t        r, r1, r4;
        logic        ab;
        logic [15:0] m;
        int          nv, na;

        tbl[0] = '{1, 0, -1, 1'b1, 16'h00F0, 16'h00F0, 1'b1};
        tbl[1] = '{4, 0, -1, 1'b1, 16'h00F0, 16'h00F0, 1'b1};
        tbl[2] = '{4, 1, -1, 1'b1, 16'hE569, 16'hE569, 1'b1};
        tbl[3] = '{1, 1, -1, 1'b1, 16'hE569, 16'hE569, 1'b1};
        tbl[4] = '{4, 1,  5, 1'b0, 16'h0000, 16'hE569, 1'b0};
        tbl[5] = '{1, 2, -1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1};
        tbl[6] = '{4, 2, -1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1};

        reset = 1'b1;
        drive(1, 1'b0, 16'h0, 1'b0, 32'h0);
        drive(4, 1'b0, 16'h0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        for (int l = 1; l <= 4; l += 3) begin
            r = sample(l);
            check("rst_busy",  {31'd0, r.busy},  32'd0);
            check("rst_valid", {31'd0, r.valid}, 32'd0);
            check("rst_ok",    {31'd0, r.ok},    32'd0);
            check("rst_abort", {31'd0, r.abort}, 32'd0);
            check("rst_calc",  {16'd0, r.calc},  32'd0);
            check("rst_recv",  {16'd0, r.recv},  32'd0);
        end
        reset = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 7; t++) begin
            load_vec(tbl[t].vec, tbl[t].flip);
            run_full($sformatf("tbl%0d", t), tbl[t].lanes, tbl[t].exp_recv, 1'b1, r);
            check($sformatf("tbl%0d_okconst", t), {31'd0, r.ok}, {31'd0, tbl[t].exp_ok});
            if (tbl[t].has_calc)
                check($sformatf("tbl%0d_calcconst", t), {16'd0, r.calc}, {16'd0, tbl[t].exp_calc});
        end

        // wordCount=3: checksum low byte shares beat 0 with payload at LANES=4
        pkt_q.delete();
        repeat (3) pkt_q.push_back(8'($urandom));
        m = model_crc(3);
        run_full("wc3_l4", 4, m, 1'b1, r4);
        void'(pkt_q.pop_back());
        void'(pkt_q.pop_back());
        run_full("wc3_l1", 1, m, 1'b1, r1);
        check("wc3_match", {16'd0, r4.calc}, {16'd0, r1.calc});

        // Restart after 10 payload bytes: abort, only packet 2 reports
        load_vec(0, -1);
        pkt_q.push_back(8'hF0);
        pkt_q.push_back(8'h00);
        send_packet(4, 24, 10, ab, r);
        nv = nval4;
        na = nab4;
        send_packet(4, 24, 26, ab, r);
        check("abort_pulse", {31'd0, ab}, 32'd1);
        check("abort_p2_valid", {31'd0, r.valid}, 32'd1);
        check("abort_p2_calc", {16'd0, r.calc}, 32'h00F0);
        check("abort_p2_ok", {31'd0, r.ok}, 32'd1);
        @(posedge clk); #1;
        check("abort_one_valid", nval4 - nv, 32'd1);
        check("abort_one_pulse", nab4 - na, 32'd1);
        check("abort_low", {31'd0, if4.abort}, 32'd0);

        // pktStart in the crcValid cycle is not an abort
        pkt_q.delete();
        repeat (5) pkt_q.push_back(8'($urandom));
        run_full("b2b_a", 1, model_crc(5), 1'b0, r);
        pkt_q.delete();
        repeat (6) pkt_q.push_back(8'($urandom));
        run_full("b2b_b", 1, model_crc(6), 1'b1, r);

        // Reset mid-payload
        load_vec(1, -1);
        send_packet(4, 24, 10, ab, r);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy", {31'd0, if4.busy}, 32'd0);
        check("midrst_valid", {31'd0, if4.crcValid}, 32'd0);
        reset = 1'b0;
        load_vec(0, -1);
        run_full("post_rst", 4, 16'h00F0, 1'b1, r);

        for (int n = 0; n < 24; n++) begin
            int          wc;
            logic [15:0] recv;
            wc = $urandom_range(0, 40);
            pkt_q.delete();
            for (int k = 0; k < wc; k++) pkt_q.push_back(8'($urandom));
            m = model_crc(wc);
            recv = ($urandom_range(0, 1) == 1) ? m : 16'($urandom);
            run_full($sformatf("rnd%0d", n), (n % 2 == 1) ? 4 : 1, recv, 1'b1, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
